// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read-port and downstream valid/ready stream bundle for fifo_drain_ctrl.
// The master modport is the drain controller; the slave modport is the FIFO plus sink side.
interface fifo_drain_ctrl_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  underflow;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output rd_en, m_data, m_valid,
        input  data_out, empty, underflow, m_ready
    );

    modport slave (
        input  rd_en, m_data, m_valid,
        output data_out, empty, underflow, m_ready
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side master for the sync FIFO: hides the 1-cycle read latency behind a 2-entry buffer.
// Optional macro FIFO_DRAIN_CNT_EN builds the delivered-word counter driving rd_count_o.
module fifo_drain_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 clr_err_i,
    output logic                 err_underflow_o,
    output logic                 idle_o,
    output logic [CNT_WIDTH-1:0] rd_count_o,
    fifo_drain_ctrl_if.master    bus
);
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [FIFO_WIDTH-1:0] head_q, head_d;
    logic [FIFO_WIDTH-1:0] skid_q, skid_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [2:0]            credit;

    assign pop  = (occ_q != 2'd0) & bus.m_ready;
    assign push = inflight_q;

    // Credit includes the same-cycle pop so a full-rate stream never bubbles.
    assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en  = ~rst & enable_i & ~bus.empty & (credit < 3'd2);

    assign bus.rd_en       = rd_en;
    assign bus.m_valid     = (occ_q != 2'd0);
    assign bus.m_data      = head_q;
    assign err_underflow_o = err_q;
    assign idle_o          = (occ_q == 2'd0) & ~inflight_q;

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        skid_d     = skid_q;
        inflight_d = rd_en & ~bus.empty;
        err_d      = bus.underflow ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = bus.data_out;
                end else begin
                    skid_d = bus.data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the skid word moves up behind the departing head.
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = bus.data_out;
                end else begin
                    head_d = bus.data_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            err_q      <= err_d;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign rd_count_o = cnt_q;
`else
    assign rd_count_o = '0;
`endif
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a behavioural FIFO feeds the DUT and a scoreboard
// queue holds the words the sink must see, in order.
module tb_fifo_drain_ctrl;
    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clr_err;
    logic          err_underflow;
    logic          idle;
    logic [CW-1:0] rd_count;

    fifo_drain_ctrl_if #(.FIFO_WIDTH(W)) bus ();

    fifo_drain_ctrl #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable),
        .clr_err_i       (clr_err),
        .err_underflow_o (err_underflow),
        .idle_o          (idle),
        .rd_count_o      (rd_count),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem[$];
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_issued = 0;
    int cnt_exp = 0;
    int first_rd = -1;
    int first_vld = -1;
    int last_vld = -1;
    int vld_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FIFO_DRAIN_CNT_EN
        return 32'(cnt_exp[CW-1:0]);
`else
        return 32'd0;
`endif
    endfunction

    task automatic preload(input logic [W-1:0] v, input bit expect_out);
        mem.push_back(v);
        if (expect_out) exp_q.push_back(v);
        bus.empty = 1'b0;
    endtask

    // One clock: observe at the falling edge, then model the FIFO just after the rising edge.
    task automatic cycle();
        logic fire;
        logic pop;
        logic push_full;
        @(negedge clk);
        cyc++;
        fire      = bus.rd_en;
        pop       = bus.m_valid & bus.m_ready;
        push_full = dut.inflight_q & (dut.occ_q == 2'd2) & ~pop;
        check("push_into_full", 32'(push_full), 32'd0);
        if (fire) begin
            rd_issued++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.m_valid) begin
            vld_cycles++;
            if (first_vld < 0) first_vld = cyc;
            last_vld = cyc;
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(bus.m_valid), 32'd0);
            end else begin
                check("m_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
                cnt_exp++;
            end
        end
        @(posedge clk);
        #1;
        if (fire && mem.size() > 0) bus.data_out = mem.pop_front();
        bus.empty = (mem.size() == 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        clr_err       = 1'b0;
        bus.empty     = 1'b1;
        bus.underflow = 1'b0;
        bus.m_ready   = 1'b0;
        bus.data_out  = '0;

        // Reset then idle
        repeat (3) cycle();
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_count", 32'(rd_count), 32'd0);
        rst = 1'b0;
        cycle();
        check("post_rst_idle", 32'(idle), 32'd1);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) preload(W'(i), 1'b1);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        first_rd = -1; first_vld = -1; last_vld = -1; vld_cycles = 0;
        drain(40);
        repeat (3) cycle();
        check("stream_latency", 32'(first_vld - first_rd), 32'd2);
        check("stream_back_to_back", 32'(last_vld - first_vld), 32'd7);
        check("stream_vld_cycles", 32'(vld_cycles), 32'd8);
        check("stream_count", 32'(rd_count), exp_count());
        check("stream_idle", 32'(idle), 32'd1);

        // Back-pressure
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) preload(16'hA000 + W'(i), 1'b1);
        rd_issued = 0;
        repeat (6) cycle();
        check("bp_reads", 32'(rd_issued), 32'd2);
        check("bp_occ", 32'(dut.occ_q), 32'd2);
        check("bp_m_valid", 32'(bus.m_valid), 32'd1);
        check("bp_hold", 32'(bus.m_data), 32'hA000);
        bus.m_ready = 1'b1;
        drain(40);
        repeat (3) cycle();
        check("bp_count", 32'(rd_count), exp_count());
        check("bp_idle", 32'(idle), 32'd1);

        // Enable drop right after the read of 0x00B3
        preload(16'h00B3, 1'b1);
        preload(16'h00B4, 1'b0);
        preload(16'h00B5, 1'b0);
        rd_issued = 0;
        cycle();
        check("b3_rd_issued", 32'(rd_issued), 32'd1);
        enable    = 1'b0;
        rd_issued = 0;
        repeat (6) cycle();
        check("b3_delivered", 32'(exp_q.size()), 32'd0);
        check("en_drop_no_rd", 32'(rd_issued), 32'd0);
        check("en_drop_idle", 32'(idle), 32'd1);
        check("en_drop_count", 32'(rd_count), exp_count());
        mem.delete();
        bus.empty = 1'b1;

        // Underflow sticky error
        bus.underflow = 1'b1;
        cycle();
        bus.underflow = 1'b0;
        check("uf_set", 32'(err_underflow), 32'd1);
        repeat (2) cycle();
        check("uf_sticky", 32'(err_underflow), 32'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("uf_clear", 32'(err_underflow), 32'd0);
        clr_err       = 1'b1;
        bus.underflow = 1'b1;
        cycle();
        clr_err       = 1'b0;
        bus.underflow = 1'b0;
        check("uf_set_wins", 32'(err_underflow), 32'd1);

        // Reset mid-operation with a buffered word and a read in flight
        enable      = 1'b1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) preload(16'hC000 + W'(i), 1'b1);
        repeat (2) cycle();
        check("mid_occ_pre", 32'(dut.occ_q), 32'd1);
        check("mid_inflight_pre", 32'(dut.inflight_q), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rd_en", 32'(bus.rd_en), 32'd0);
        exp_q.delete();
        mem.delete();
        bus.empty = 1'b1;
        cnt_exp   = 0;
        repeat (2) cycle();
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        vld_cycles  = 0;
        repeat (5) cycle();
        check("mid_no_stale", 32'(vld_cycles), 32'd0);
        check("mid_idle", 32'(idle), 32'd1);
        check("mid_count", 32'(rd_count), 32'd0);
        check("mid_err", 32'(err_underflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
